// File: rtl/seq_shift_unit_pkg.sv
// Shared constants for the sequential shifter: operation codes and FSM state encoding.
package shifter_pkg;

  localparam logic [2:0] MODE_PASS = 3'b000;
  localparam logic [2:0] MODE_LSL  = 3'b001;
  localparam logic [2:0] MODE_LSR  = 3'b010;
  localparam logic [2:0] MODE_ASR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_LSL1 = 3'b110;
  localparam logic [2:0] MODE_LSR1 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shift_unit_if.sv
// Request/result bundle of the sequential shifter, plus a debug view of the FSM state.
// Handshake: start is honoured only while busy==0; done pulses one cycle with r valid,
// and busy stays high from the accept edge until the edge that ends the done cycle.
interface seq_shift_unit_if #(
  parameter int WIDTH = 8
) ();
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [2:0]         mode;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   r;
  logic [1:0]         dbg_state;

  modport master (
    output start, a, mode, shamt,
    input  busy, done, r, dbg_state
  );

  modport slave (
    input  start, a, mode, shamt,
    output busy, done, r, dbg_state
  );
endinterface

// File: rtl/seq_shift_unit_step.sv
// One-bit-position step of every shifter operation; purely combinational.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = x;
    case (mode)
      MODE_PASS: y = x;
      MODE_LSL:  y = {x[WIDTH-2:0], 1'b0};
      MODE_LSR:  y = {1'b0, x[WIDTH-1:1]};
      // the MSB of the work register is the original sign, so it carries forward every step
      MODE_ASR:  y = {x[WIDTH-1], x[WIDTH-1:1]};
      MODE_ROL:  y = {x[WIDTH-2:0], x[WIDTH-1]};
      MODE_ROR:  y = {x[0], x[WIDTH-1:1]};
      MODE_LSL1: y = {x[WIDTH-2:0], 1'b1};
      MODE_LSR1: y = {1'b1, x[WIDTH-1:1]};
      default:   y = x;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter/rotator: one bit position per clock, start/busy/done handshake.
module seq_shift_unit
  import shifter_pkg::*;
#(
  parameter  int WIDTH   = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_shift_unit_if.slave bus
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   step_y;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .mode (mode_q),
    .x    (work_q),
    .y    (step_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_PASS;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    r_d      = r_q;
    bus.done = 1'b0;
    bus.busy = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          work_d = bus.a;
          cnt_d  = bus.shamt;
          mode_d = bus.mode;
          // nothing to step: publish the operand directly
          if (bus.shamt == '0 || bus.mode == MODE_PASS) begin
            r_d     = bus.a;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        work_d = step_y;
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          r_d     = step_y;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.r         = r_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit (WIDTH=8): latency, result, handshake and reset checks.
module tb_seq_shift_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [7:0] exp_q[$];

  seq_shift_unit_if #(.WIDTH(8)) bus_if ();

  seq_shift_unit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one operation: drive, wait (bounded) for done, compare latency/result/handshake
  task automatic run_op(input logic [7:0] a_i, input logic [2:0] m_i, input logic [2:0] s_i,
                        input logic [7:0] exp_r, input int exp_lat, input bit spam,
                        input string tag);
    int lat;
    exp_q.push_back(exp_r);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = a_i;
    bus_if.mode  = m_i;
    bus_if.shamt = s_i;
    @(posedge clk);
    #1;
    // inputs change after accept; only latched copies may matter
    bus_if.start = spam;
    bus_if.a     = ~a_i;
    bus_if.mode  = ~m_i;
    bus_if.shamt = ~s_i;
    chk(bus_if.busy, 1, {tag, "_busy_after_accept"});
    lat = 0;
    while (bus_if.done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    bus_if.start = 1'b0;
    chk(lat, exp_lat, {tag, "_latency"});
    chk(bus_if.r, exp_q.pop_front(), {tag, "_r"});
    chk(bus_if.busy, 1, {tag, "_busy_with_done"});
    @(posedge clk);
    #1;
    chk(bus_if.done, 0, {tag, "_done_single"});
    chk(bus_if.busy, 0, {tag, "_busy_fall"});
    chk(bus_if.r, exp_r, {tag, "_r_hold"});
    if (spam) begin
      repeat (3) begin
        @(posedge clk);
        #1;
        chk(bus_if.done, 0, {tag, "_no_queued_done"});
        chk(bus_if.busy, 0, {tag, "_no_queued_busy"});
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.mode  = '0;
    bus_if.shamt = '0;
    #12;
    chk(bus_if.busy, 0, "reset_busy");
    chk(bus_if.done, 0, "reset_done");
    chk(bus_if.r, 8'h00, "reset_r");
    chk(bus_if.dbg_state, 2'd0, "reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'b0000_0101, 3'b001, 3'd3, 8'b0010_1000, 3, 1'b0, "lsl3");
    run_op(8'b1010_0000, 3'b010, 3'd5, 8'b0000_0101, 5, 1'b0, "lsr5");
    run_op(8'b1001_0000, 3'b011, 3'd2, 8'b1110_0100, 2, 1'b0, "asr2");
    run_op(8'h00,        3'b110, 3'd4, 8'h0F,        4, 1'b0, "lsl1_fill");
    run_op(8'h00,        3'b111, 3'd4, 8'hF0,        4, 1'b0, "lsr1_fill");
    run_op(8'b0000_0011, 3'b101, 3'd1, 8'b1000_0001, 1, 1'b0, "ror1");
    run_op(8'b1000_0000, 3'b100, 3'd7, 8'b0100_0000, 7, 1'b0, "rol7");
    run_op(8'h5A,        3'b000, 3'd6, 8'h5A,        0, 1'b0, "pass");
    run_op(8'hC3,        3'b001, 3'd0, 8'hC3,        0, 1'b0, "lsl0");
    run_op(8'b0000_0101, 3'b001, 3'd3, 8'b0010_1000, 3, 1'b1, "busy_ignore");

    // reset in the middle of a shift
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = 8'hFF;
    bus_if.mode  = 3'b001;
    bus_if.shamt = 3'd5;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk(bus_if.dbg_state, 2'd1, "midop_in_shift");
    rst_n = 1'b0;
    #1;
    chk(bus_if.busy, 0, "midop_reset_busy");
    chk(bus_if.done, 0, "midop_reset_done");
    chk(bus_if.r, 8'h00, "midop_reset_r");
    chk(bus_if.dbg_state, 2'd0, "midop_reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h01, 3'b001, 3'd1, 8'h02, 1, 1'b0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
